// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - opcode map, ALU unit encodings, state and class enums
package ctrl_pkg;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_MUL  = 2;
    localparam int OP_DIV  = 3;
    localparam int OP_MOD  = 4;
    localparam int OP_CMP  = 5;
    localparam int OP_MOV  = 6;
    localparam int OP_AND  = 7;
    localparam int OP_OR   = 8;
    localparam int OP_XOR  = 9;
    localparam int OP_NOT  = 10;
    localparam int OP_SHL  = 11;
    localparam int OP_SHR  = 12;
    localparam int OP_LD   = 14;
    localparam int OP_ST   = 15;
    localparam int OP_BEQ  = 16;
    localparam int OP_BGT  = 17;
    localparam int OP_B    = 18;
    localparam int OP_CALL = 19;
    localparam int OP_RET  = 20;
    localparam int OP_HALT = 31;

    localparam int ALU_ADDSUB = 0;
    localparam int ALU_MUL    = 1;
    localparam int ALU_DIV    = 2;
    localparam int ALU_MOV    = 3;
    localparam int ALU_LOGIC  = 4;
    localparam int ALU_SHIFT  = 5;

    typedef enum logic [2:0] {
        ST_IDLE, ST_INIT, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_e;

    typedef enum logic [3:0] {
        CLS_ALU, CLS_CMP, CLS_LD, CLS_ST, CLS_BEQ, CLS_BGT,
        CLS_JMP, CLS_CALL, CLS_RET, CLS_HALT, CLS_ILL
    } cls_e;

    function automatic logic is_branch(input cls_e c);
        return (c == CLS_BEQ) || (c == CLS_BGT) || (c == CLS_JMP) ||
               (c == CLS_CALL) || (c == CLS_RET);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - decode-side inputs and datapath strobes of the sequencer
interface multicycle_ctrl_if #(
    parameter int OPCODE_W = 5,
    parameter int ALUSEL_W = 3
);
    logic                start;
    logic [OPCODE_W-1:0] opcode;
    logic                flagE;
    logic                flagGt;
    logic                memReady;

    logic                clrAll;
    logic                ldInst;
    logic                ldNPC;
    logic                ldDecodeInst;
    logic                ldRegOutputData;
    logic                ldResult;
    logic                wrFlag;
    logic                memReq;
    logic                isLd;
    logic                isSt;
    logic                isRegWriteback;
    logic                ldPC;
    logic                isBranchTaken;
    logic                isCall;
    logic                isRet;
    logic [ALUSEL_W-1:0] aluSel;
    logic [3:0]          aluOp;
    logic                busy;
    logic                halted;
    logic                illegal;
    logic                memErr;

    modport master (
        input  start, opcode, flagE, flagGt, memReady,
        output clrAll, ldInst, ldNPC, ldDecodeInst, ldRegOutputData, ldResult, wrFlag,
               memReq, isLd, isSt, isRegWriteback, ldPC, isBranchTaken, isCall, isRet,
               aluSel, aluOp, busy, halted, illegal, memErr
    );

    modport slave (
        output start, opcode, flagE, flagGt, memReady,
        input  clrAll, ldInst, ldNPC, ldDecodeInst, ldRegOutputData, ldResult, wrFlag,
               memReq, isLd, isSt, isRegWriteback, ldPC, isBranchTaken, isCall, isRet,
               aluSel, aluOp, busy, halted, illegal, memErr
    );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// rtl/multicycle_ctrl_decode.sv - combinational opcode to class / ALU select / op index
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter int ALUSEL_W = 3
) (
    input  logic [OPCODE_W-1:0] opcode,
    output cls_e                cls,
    output logic [ALUSEL_W-1:0] alu_sel,
    output logic [3:0]          alu_op,
    output logic                is_long,
    output logic                illegal
);
    logic [31:0] op_ext;
    int          unit;

    always_comb begin
        op_ext  = 32'(opcode);
        cls     = CLS_ILL;
        unit    = ALU_ADDSUB;
        alu_op  = '0;
        is_long = 1'b0;
        case (op_ext)
            OP_ADD, OP_SUB:                 cls = CLS_ALU;
            OP_CMP:                         cls = CLS_CMP;
            OP_MUL:                         begin cls = CLS_ALU; unit = ALU_MUL; is_long = 1'b1; end
            OP_DIV, OP_MOD:                 begin cls = CLS_ALU; unit = ALU_DIV; is_long = 1'b1; end
            OP_MOV:                         begin cls = CLS_ALU; unit = ALU_MOV; end
            OP_AND, OP_OR, OP_XOR, OP_NOT:  begin cls = CLS_ALU; unit = ALU_LOGIC; end
            OP_SHL, OP_SHR:                 begin cls = CLS_ALU; unit = ALU_SHIFT; end
            OP_LD:                          cls = CLS_LD;
            OP_ST:                          cls = CLS_ST;
            OP_BEQ:                         cls = CLS_BEQ;
            OP_BGT:                         cls = CLS_BGT;
            OP_B:                           cls = CLS_JMP;
            OP_CALL:                        cls = CLS_CALL;
            OP_RET:                         cls = CLS_RET;
            OP_HALT:                        cls = CLS_HALT;
            default:                        cls = CLS_ILL;
        endcase
        // Memory ops reuse the adder for address generation with op index 0.
        if (op_ext <= 32'(OP_SHR)) alu_op = op_ext[3:0];
        alu_sel = ALUSEL_W'(unit);
        illegal = (cls == CLS_ILL);
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle instruction sequencer driving datapath strobes
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 5,
    parameter int ALUSEL_W    = 3,
    parameter int EXEC_CYCLES = 2,
    parameter int LONG_CYCLES = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input logic              clk,
    input logic              rstN,
    multicycle_ctrl_if.master bus
);
    localparam int EXEC_MAX = (LONG_CYCLES > EXEC_CYCLES) ? LONG_CYCLES : EXEC_CYCLES;
    localparam int EW       = $clog2(EXEC_MAX + 1);
    localparam int MW       = $clog2(MEM_TIMEOUT + 1);

    state_e              state_q, state_d;
    cls_e                cls_q, cls_d;
    logic [ALUSEL_W-1:0] alu_sel_q, alu_sel_d;
    logic [3:0]          alu_op_q, alu_op_d;
    logic                taken_q, taken_d;
    logic [EW-1:0]       exec_cnt_q, exec_cnt_d;
    logic [MW-1:0]       mem_cnt_q, mem_cnt_d;
    logic                mem_err_q, mem_err_d;

    cls_e                dec_cls;
    logic [ALUSEL_W-1:0] dec_alu_sel;
    logic [3:0]          dec_alu_op;
    logic                dec_long;
    logic                dec_illegal;

    ctrl_decode #(.OPCODE_W(OPCODE_W), .ALUSEL_W(ALUSEL_W)) u_decode (
        .opcode  (bus.opcode),
        .cls     (dec_cls),
        .alu_sel (dec_alu_sel),
        .alu_op  (dec_alu_op),
        .is_long (dec_long),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= ST_IDLE;
            cls_q      <= CLS_ALU;
            alu_sel_q  <= '0;
            alu_op_q   <= '0;
            taken_q    <= 1'b0;
            exec_cnt_q <= '0;
            mem_cnt_q  <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            alu_sel_q  <= alu_sel_d;
            alu_op_q   <= alu_op_d;
            taken_q    <= taken_d;
            exec_cnt_q <= exec_cnt_d;
            mem_cnt_q  <= mem_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        alu_sel_d  = alu_sel_q;
        alu_op_d   = alu_op_q;
        taken_d    = taken_q;
        exec_cnt_d = exec_cnt_q;
        mem_cnt_d  = mem_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            ST_IDLE, ST_HALT: if (bus.start) state_d = ST_INIT;
            ST_INIT:  state_d = ST_FETCH;
            ST_FETCH: begin
                mem_err_d = 1'b0;
                state_d   = ST_DECODE;
            end
            ST_DECODE: begin
                cls_d      = dec_cls;
                alu_sel_d  = dec_alu_sel;
                alu_op_d   = dec_alu_op;
                taken_d    = ((dec_cls == CLS_BEQ) && bus.flagE) ||
                             ((dec_cls == CLS_BGT) && bus.flagGt) ||
                             (dec_cls == CLS_JMP) || (dec_cls == CLS_CALL) || (dec_cls == CLS_RET);
                exec_cnt_d = dec_long ? EW'(LONG_CYCLES - 1) : EW'(EXEC_CYCLES - 1);
                mem_cnt_d  = '0;
                if (dec_cls == CLS_HALT)                     state_d = ST_HALT;
                else if (is_branch(dec_cls) || dec_illegal)  state_d = ST_WB;
                else                                         state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (exec_cnt_q == '0)
                    state_d = ((cls_q == CLS_LD) || (cls_q == CLS_ST)) ? ST_MEM : ST_WB;
                else
                    exec_cnt_d = exec_cnt_q - 1'b1;
            end
            ST_MEM: begin
                // memReady wins over a timeout landing on the same cycle.
                if (bus.memReady) begin
                    state_d = ST_WB;
                end else if (mem_cnt_q == MW'(MEM_TIMEOUT - 1)) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_WB;
                end else begin
                    mem_cnt_d = mem_cnt_q + 1'b1;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.clrAll          = 1'b0;
        bus.ldInst          = 1'b0;
        bus.ldNPC           = 1'b0;
        bus.ldDecodeInst    = 1'b0;
        bus.ldRegOutputData = 1'b0;
        bus.ldResult        = 1'b0;
        bus.wrFlag          = 1'b0;
        bus.memReq          = 1'b0;
        bus.isLd            = 1'b0;
        bus.isSt            = 1'b0;
        bus.isRegWriteback  = 1'b0;
        bus.ldPC            = 1'b0;
        bus.isBranchTaken   = 1'b0;
        bus.isCall          = 1'b0;
        bus.isRet           = 1'b0;
        bus.halted          = 1'b0;
        bus.illegal         = 1'b0;
        bus.memErr          = 1'b0;
        bus.aluSel          = alu_sel_q;
        bus.aluOp           = alu_op_q;
        bus.busy            = (state_q != ST_IDLE) && (state_q != ST_HALT);
        case (state_q)
            ST_INIT:  bus.clrAll = 1'b1;
            ST_FETCH: begin
                bus.ldInst = 1'b1;
                bus.ldNPC  = 1'b1;
            end
            ST_DECODE: begin
                bus.ldDecodeInst    = 1'b1;
                bus.ldRegOutputData = 1'b1;
            end
            ST_EXEC: begin
                bus.ldResult = (exec_cnt_q == '0);
                bus.wrFlag   = (exec_cnt_q == '0) && (cls_q == CLS_CMP);
            end
            ST_MEM: begin
                bus.memReq = 1'b1;
                bus.isLd   = (cls_q == CLS_LD);
                bus.isSt   = (cls_q == CLS_ST);
            end
            ST_WB: begin
                bus.ldPC           = 1'b1;
                bus.isRegWriteback = (cls_q == CLS_ALU) || ((cls_q == CLS_LD) && !mem_err_q);
                bus.isBranchTaken  = taken_q;
                bus.isCall         = (cls_q == CLS_CALL);
                bus.isRet          = (cls_q == CLS_RET);
                bus.illegal        = (cls_q == CLS_ILL);
                bus.memErr         = mem_err_q;
            end
            ST_HALT:  bus.halted = 1'b1;
            default:  ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for the multi-cycle sequencer
module tb_multicycle_ctrl;
    localparam int OPCODE_W    = 5;
    localparam int ALUSEL_W    = 3;
    localparam int EXEC_CYCLES = 2;
    localparam int LONG_CYCLES = 4;
    localparam int MEM_TIMEOUT = 15;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.OPCODE_W(OPCODE_W), .ALUSEL_W(ALUSEL_W)) bus ();

    multicycle_ctrl #(
        .OPCODE_W(OPCODE_W), .ALUSEL_W(ALUSEL_W), .EXEC_CYCLES(EXEC_CYCLES),
        .LONG_CYCLES(LONG_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    typedef struct {
        int cycles; int ldres; int wrf; int mem; int nld; int nst; int ill; int merr;
        int wb; int br; int call; int ret; int chk_alu; int alusel; int aluop;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.clrAll, bus.ldInst, bus.ldNPC, bus.ldDecodeInst, bus.ldRegOutputData,
                    bus.ldResult, bus.wrFlag, bus.memReq, bus.isLd, bus.isSt, bus.isRegWriteback,
                    bus.ldPC, bus.isBranchTaken, bus.isCall, bus.isRet, bus.busy, bus.halted,
                    bus.illegal, bus.memErr, bus.aluSel, bus.aluOp});
    endfunction

    // Reference behaviour: one instruction from FETCH to its WB cycle.
    function automatic exp_t model(input int op, input bit fe, input bit fg, input int md);
        int   unit_tab[13] = '{0, 0, 1, 2, 2, 0, 3, 4, 4, 4, 4, 5, 5};
        exp_t e;
        e = '{default: 0};
        if (op <= 12) begin
            e.mem = 0;
            e.ldres = 1;
            e.wrf = (op == 5) ? 1 : 0;
            e.wb = (op == 5) ? 0 : 1;
            e.chk_alu = 1;
            e.alusel = unit_tab[op];
            e.aluop = op;
            e.cycles = 2 + ((op >= 2 && op <= 4) ? LONG_CYCLES : EXEC_CYCLES);
        end else if (op == 14 || op == 15) begin
            e.mem = (md > 0) ? md : MEM_TIMEOUT;
            e.merr = (md > 0) ? 0 : 1;
            e.ldres = 1;
            e.nld = (op == 14) ? e.mem : 0;
            e.nst = (op == 15) ? e.mem : 0;
            e.wb = (op == 14 && md > 0) ? 1 : 0;
            e.chk_alu = 1;
            e.cycles = 2 + EXEC_CYCLES + e.mem;
        end else if (op >= 16 && op <= 20) begin
            e.br = (op == 16) ? int'(fe) : (op == 17) ? int'(fg) : 1;
            e.call = (op == 19) ? 1 : 0;
            e.ret = (op == 20) ? 1 : 0;
            e.cycles = 2;
        end else begin
            e.ill = 1;
            e.cycles = 2;
        end
        return e;
    endfunction

    task automatic wait_fetch(input string tag);
        int lim = 0;
        while (!bus.ldInst && lim < 64) begin
            @(negedge clk);
            lim++;
        end
        if (!bus.ldInst) check({tag, "_fetch_wait"}, 32'(bus.ldInst), 32'd1);
    endtask

    task automatic run_instr(input int op, input bit fe, input bit fg, input int md);
        exp_t  e;
        string tag;
        int t = 0, n_ldres = 0, n_wrf = 0, n_mreq = 0, n_ld = 0, n_st = 0, n_ill = 0, n_merr = 0;
        tag = $sformatf("op%0d_fe%0d_fg%0d_md%0d", op, fe, fg, md);
        wait_fetch(tag);
        if (!bus.ldInst) return;
        bus.opcode   = OPCODE_W'(op);
        bus.flagE    = fe;
        bus.flagGt   = fg;
        bus.memReady = 1'b0;
        sb.push_back(model(op, fe, fg, md));
        do begin
            @(negedge clk);
            t++;
            if (bus.ldResult) n_ldres++;
            if (bus.wrFlag)   n_wrf++;
            if (bus.illegal)  n_ill++;
            if (bus.memErr)   n_merr++;
            if (bus.memReq) begin
                n_mreq++;
                if (bus.isLd) n_ld++;
                if (bus.isSt) n_st++;
                bus.memReady = (md > 0) && (n_mreq >= md);
            end
        end while (!bus.ldPC && t < 100);
        e = sb.pop_front();
        check({tag, "_wb_cycle"},   32'(t),                  32'(e.cycles));
        check({tag, "_ldresult"},   32'(n_ldres),            32'(e.ldres));
        check({tag, "_wrflag"},     32'(n_wrf),              32'(e.wrf));
        check({tag, "_memreq"},     32'(n_mreq),             32'(e.mem));
        check({tag, "_isld"},       32'(n_ld),               32'(e.nld));
        check({tag, "_isst"},       32'(n_st),               32'(e.nst));
        check({tag, "_illegal"},    32'(n_ill),              32'(e.ill));
        check({tag, "_memerr"},     32'(n_merr),             32'(e.merr));
        check({tag, "_writeback"},  32'(bus.isRegWriteback), 32'(e.wb));
        check({tag, "_taken"},      32'(bus.isBranchTaken),  32'(e.br));
        check({tag, "_call"},       32'(bus.isCall),         32'(e.call));
        check({tag, "_ret"},        32'(bus.isRet),          32'(e.ret));
        if (e.chk_alu != 0) begin
            check({tag, "_alusel"}, 32'(bus.aluSel), 32'(e.alusel));
            check({tag, "_aluop"},  32'(bus.aluOp),  32'(e.aluop));
        end
        bus.memReady = 1'b0;
    endtask

    initial begin
        int lim;
        bus.start    = 1'b0;
        bus.opcode   = '0;
        bus.flagE    = 1'b0;
        bus.flagGt   = 1'b0;
        bus.memReady = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", outs(), 32'd0);
        rstN = 1'b1;
        @(negedge clk);
        check("idle_without_start", outs(), 32'd0);

        bus.start = 1'b1;
        @(negedge clk);
        check("init_clrall", 32'(bus.clrAll), 32'd1);
        bus.start = 1'b0;
        @(negedge clk);
        check("init_single_cycle", 32'({bus.clrAll, bus.ldInst, bus.ldNPC}), 32'b011);

        for (int op = 0; op <= 12; op++) run_instr(op, 1'b0, 1'b0, 0);
        run_instr(16, 1'b0, 1'b1, 0);
        run_instr(16, 1'b1, 1'b0, 0);
        run_instr(17, 1'b1, 1'b0, 0);
        run_instr(17, 1'b0, 1'b1, 0);
        run_instr(18, 1'b0, 1'b0, 0);
        run_instr(19, 1'b0, 1'b0, 0);
        run_instr(20, 1'b0, 1'b0, 0);
        run_instr(14, 1'b0, 1'b0, 3);
        run_instr(15, 1'b0, 1'b0, 1);
        run_instr(14, 1'b0, 1'b0, 0);
        run_instr(25, 1'b0, 1'b0, 0);
        run_instr(13, 1'b0, 1'b0, 0);
        run_instr(0,  1'b0, 1'b0, 1);

        wait_fetch("halt");
        bus.opcode = OPCODE_W'(31);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("halt_hold%0d", i), 32'({bus.halted, bus.busy, bus.ldInst}), 32'b100);
        end
        bus.start = 1'b1;
        @(negedge clk);
        check("halt_restart", 32'({bus.clrAll, bus.halted}), 32'b10);
        bus.start = 1'b0;

        wait_fetch("reset_mid_mem");
        bus.opcode   = OPCODE_W'(14);
        bus.memReady = 1'b0;
        lim = 0;
        while (!bus.memReq && lim < 32) begin
            @(negedge clk);
            lim++;
        end
        check("reach_mem", 32'(bus.memReq), 32'd1);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_reset_idle%0d", i), outs(), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
